// File: rtl/ram_access_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_access_arbiter_pkg                                                |
// | Shared types and default memory-map constants for the RAM front-end. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ram_access_arbiter_pkg;

  // Defaults shared with the mega_ram parameterisation.
  localparam int unsigned c_DEF_CLEAR_DEPTH = 256;
  localparam int unsigned c_DEF_WRITE_LIMIT = 'hB00;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } rd_owner_t;

endpackage : ram_access_arbiter_pkg
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_clear_seq                                                         |
// | Post-reset zero-fill address generator for the low RAM region.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ram_clear_seq
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 12,
  parameter int CLEAR_DEPTH    = c_DEF_CLEAR_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_active,
  output logic                      o_we,
  output logic [ADDR_BUS_WIDTH-1:0] o_addr,
  output logic                      o_done
);

  localparam logic [ADDR_BUS_WIDTH-1:0] c_LAST_ADDR = ADDR_BUS_WIDTH'(CLEAR_DEPTH - 1);

  logic [ADDR_BUS_WIDTH-1:0] r_cnt;
  logic                      w_last;

  assign w_last = (r_cnt == c_LAST_ADDR);

  // Counter rewinds on completion so a later reset-free re-entry starts at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_active) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_we   = i_active;
  assign o_addr = r_cnt;
  assign o_done = i_active & w_last;

endmodule : ram_clear_seq
`default_nettype wire

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_access_arbiter                                                    |
// | Clears low RAM after reset, then arbitrates CPU/DMA access to it.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 12,
  parameter int DATA_BUS_WIDTH = 8,
  parameter int CLEAR_DEPTH    = c_DEF_CLEAR_DEPTH,
  parameter int WRITE_LIMIT    = c_DEF_WRITE_LIMIT,
  parameter int DMA_MAX_WAIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_cs,
  input  logic                      cpu_we,
  input  logic                      cpu_re,
  input  logic [ADDR_BUS_WIDTH-1:0] cpu_a,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_d_in,
  output logic [DATA_BUS_WIDTH-1:0] cpu_d_out,
  output logic                      cpu_halt,
  input  logic                      dma_req,
  input  logic                      dma_we,
  input  logic [ADDR_BUS_WIDTH-1:0] dma_a,
  input  logic [DATA_BUS_WIDTH-1:0] dma_d_in,
  output logic                      dma_gnt,
  output logic                      dma_valid,
  output logic [DATA_BUS_WIDTH-1:0] dma_d_out,
  output logic                      ram_cs,
  output logic                      ram_we,
  output logic                      ram_re,
  output logic [ADDR_BUS_WIDTH-1:0] ram_a,
  output logic [DATA_BUS_WIDTH-1:0] ram_d_wr,
  input  logic [DATA_BUS_WIDTH-1:0] ram_d_rd
);

  localparam int                        c_WAIT_W = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0]       c_WAIT_MAX = c_WAIT_W'(DMA_MAX_WAIT);
  localparam logic [ADDR_BUS_WIDTH-1:0] c_LIMIT = ADDR_BUS_WIDTH'(WRITE_LIMIT);

  arb_state_t                r_state;
  rd_owner_t                 r_rd_owner;
  logic [c_WAIT_W-1:0]       r_wait_cnt;

  logic                      w_in_clear;
  logic                      w_clr_we;
  logic                      w_clr_done;
  logic [ADDR_BUS_WIDTH-1:0] w_clr_addr;
  logic                      w_cpu_rq;
  logic                      w_dma_forced;
  logic                      w_dma_win;
  logic                      w_cpu_win;

  assign w_in_clear = (r_state == ST_CLEAR);

  ram_clear_seq #(
    .ADDR_BUS_WIDTH (ADDR_BUS_WIDTH),
    .CLEAR_DEPTH    (CLEAR_DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .i_active (w_in_clear),
    .o_we     (w_clr_we),
    .o_addr   (w_clr_addr),
    .o_done   (w_clr_done)
  );

  // CPU has priority unless DMA has already lost DMA_MAX_WAIT cycles in a row.
  assign w_cpu_rq     = cpu_cs & (cpu_we | cpu_re);
  assign w_dma_forced = (r_wait_cnt == c_WAIT_MAX);
  assign w_dma_win    = ~w_in_clear & dma_req & (~w_cpu_rq | w_dma_forced);
  assign w_cpu_win    = ~w_in_clear & w_cpu_rq & ~w_dma_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_wait_cnt <= '0;
      r_rd_owner <= OWN_NONE;
    end else if (w_in_clear) begin
      r_wait_cnt <= '0;
      r_rd_owner <= OWN_NONE;
      if (w_clr_done) begin
        r_state <= ST_RUN;
      end
    end else begin
      if (!dma_req || w_dma_win) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != c_WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_dma_win && !dma_we) begin
        r_rd_owner <= OWN_DMA;
      end else if (w_cpu_win && cpu_re) begin
        r_rd_owner <= OWN_CPU;
      end else begin
        r_rd_owner <= OWN_NONE;
      end
    end
  end

  // Protected writes still consume the grant; only the write strobe is dropped.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_a    = '0;
    ram_d_wr = '0;
    if (w_in_clear) begin
      ram_cs = 1'b1;
      ram_we = w_clr_we;
      ram_a  = w_clr_addr;
    end else if (w_dma_win) begin
      ram_cs   = 1'b1;
      ram_we   = dma_we & (dma_a < c_LIMIT);
      ram_re   = ~dma_we;
      ram_a    = dma_a;
      ram_d_wr = dma_d_in;
    end else if (w_cpu_win) begin
      ram_cs   = 1'b1;
      ram_we   = cpu_we & (cpu_a < c_LIMIT);
      ram_re   = cpu_re;
      ram_a    = cpu_a;
      ram_d_wr = cpu_d_in;
    end
  end

  assign dma_gnt   = w_dma_win;
  assign cpu_halt  = w_in_clear | (w_cpu_rq & w_dma_win);
  assign cpu_d_out = (r_rd_owner == OWN_CPU) ? ram_d_rd : '0;
  assign dma_valid = (r_rd_owner == OWN_DMA);
  assign dma_d_out = (r_rd_owner == OWN_DMA) ? ram_d_rd : '0;

endmodule : ram_access_arbiter
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_access_arbiter                                                 |
// | Self-checking bench: directed scenarios plus a randomized model run. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ram_access_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int CD = 256;
  localparam int WL = 'hB00;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_cs, cpu_we, cpu_re;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_d_in, cpu_d_out;
  logic          cpu_halt;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_a;
  logic [DW-1:0] dma_d_in, dma_d_out;
  logic          dma_gnt, dma_valid;
  logic          ram_cs, ram_we, ram_re;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d_wr, ram_d_rd;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  ram_access_arbiter #(
    .ADDR_BUS_WIDTH (AW),
    .DATA_BUS_WIDTH (DW),
    .CLEAR_DEPTH    (CD),
    .WRITE_LIMIT    (WL),
    .DMA_MAX_WAIT   (MW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_cs    (cpu_cs),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_a     (cpu_a),
    .cpu_d_in  (cpu_d_in),
    .cpu_d_out (cpu_d_out),
    .cpu_halt  (cpu_halt),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_a     (dma_a),
    .dma_d_in  (dma_d_in),
    .dma_gnt   (dma_gnt),
    .dma_valid (dma_valid),
    .dma_d_out (dma_d_out),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_a     (ram_a),
    .ram_d_wr  (ram_d_wr),
    .ram_d_rd  (ram_d_rd)
  );

  function automatic logic [DW-1:0] seed_val(input int i);
    return DW'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // Single-port RAM macro: registered read, write-first not needed (one access per cycle).
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= seed_val(i);
      mem_ready <= 1'b1;
    end else if (ram_cs) begin
      if (ram_we) mem[ram_a] <= ram_d_wr;
      if (ram_re) ram_d_rd <= mem[ram_a];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cs, input logic we, input logic re,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] dd);
    cpu_cs = cs; cpu_we = we; cpu_re = re; cpu_a = a; cpu_d_in = d;
    dma_req = dr; dma_we = dw; dma_a = da; dma_d_in = dd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drive_random_req();
    drive(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
          1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({cpu_halt, dma_gnt, dma_valid, cpu_d_out, dma_d_out} !== {1'b1, 1'b0, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got halt=%b gnt=%b valid=%b cpu_d=%h dma_d=%h, expected 1 0 0 00 00",
               cpu_halt, dma_gnt, dma_valid, cpu_d_out, dma_d_out);
    end
    checks++;
    if ({ram_cs, ram_we, ram_a, ram_d_wr} !== {1'b1, 1'b1, 12'h000, 8'h00}) begin
      errors++;
      $display("FAIL reset_ram_bus: got cs=%b we=%b a=%h d=%h, expected 1 1 000 00",
               ram_cs, ram_we, ram_a, ram_d_wr);
    end
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < CD; i++) begin
      drive_random_req();
      @(negedge clk);
      checks++;
      if ({ram_cs, ram_we, ram_re, ram_a, ram_d_wr, cpu_halt, dma_gnt} !==
          {1'b1, 1'b1, 1'b0, AW'(i), 8'h00, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL clear_cycle_%0d: got cs=%b we=%b re=%b a=%h d=%h halt=%b gnt=%b, expected 1 1 0 %h 00 1 0",
                 i, ram_cs, ram_we, ram_re, ram_a, ram_d_wr, cpu_halt, dma_gnt, AW'(i));
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if ({cpu_halt, ram_cs, dma_valid, cpu_d_out} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL clear_done: got halt=%b cs=%b valid=%b cpu_d=%h, expected 0 0 0 00",
               cpu_halt, ram_cs, dma_valid, cpu_d_out);
    end
    bad = 0;
    for (int i = 0; i < CD; i++) if (mem[i] !== 8'h00) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_contents: %0d nonzero words in 0x000..0x0FF, expected 0", bad);
    end
    for (int i = 0; i < CD; i++) ref_mem[i] = 8'h00;
    next_cycle();
  endtask

  task automatic test_cpu_rw();
    drive(1'b1, 1'b1, 1'b0, 12'h120, 8'h5A, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({ram_cs, ram_we, ram_re, ram_a, ram_d_wr, cpu_halt} !== {1'b1, 1'b1, 1'b0, 12'h120, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL cpu_write_bus: got cs=%b we=%b re=%b a=%h d=%h halt=%b, expected 1 1 0 120 5a 0",
               ram_cs, ram_we, ram_re, ram_a, ram_d_wr, cpu_halt);
    end
    ref_mem[12'h120] = 8'h5A;
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 12'h120, 8'h00, 1'b0, 1'b0, '0, '0);
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if ({cpu_d_out, dma_valid} !== {8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL cpu_readback: got cpu_d=%h valid=%b, expected 5a 0", cpu_d_out, dma_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (cpu_d_out !== 8'h00) begin
      errors++;
      $display("FAIL cpu_d_out_idle: got %h, expected 00", cpu_d_out);
    end
    next_cycle();
  endtask

  task automatic test_dma_read();
    drive(1'b1, 1'b1, 1'b0, 12'h050, 8'hC3, 1'b0, 1'b0, '0, '0);
    ref_mem[12'h050] = 8'hC3;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h050, 8'h00);
    @(negedge clk);
    checks++;
    if ({dma_gnt, ram_cs, ram_re, ram_we, ram_a} !== {1'b1, 1'b1, 1'b1, 1'b0, 12'h050}) begin
      errors++;
      $display("FAIL dma_read_grant: got gnt=%b cs=%b re=%b we=%b a=%h, expected 1 1 1 0 050",
               dma_gnt, ram_cs, ram_re, ram_we, ram_a);
    end
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if ({dma_valid, dma_d_out, cpu_d_out} !== {1'b1, 8'hC3, 8'h00}) begin
      errors++;
      $display("FAIL dma_read_data: got valid=%b dma_d=%h cpu_d=%h, expected 1 c3 00",
               dma_valid, dma_d_out, cpu_d_out);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({dma_valid, dma_d_out} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL dma_valid_drop: got valid=%b dma_d=%h, expected 0 00", dma_valid, dma_d_out);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [AW-1:0] p;
    logic          exp_gnt;
    p = 12'h200;
    for (int k = 1; k <= 6; k++) begin
      exp_gnt = (k == MW + 1);
      drive(1'b1, 1'b1, 1'b0, p, p[7:0], (k <= MW + 1), 1'b1, 12'h300, 8'h77);
      @(negedge clk);
      checks++;
      if ({dma_gnt, cpu_halt, ram_a} !== {exp_gnt, exp_gnt, exp_gnt ? 12'h300 : p}) begin
        errors++;
        $display("FAIL starve_cycle_%0d: got gnt=%b halt=%b a=%h, expected %b %b %h",
                 k, dma_gnt, cpu_halt, ram_a, exp_gnt, exp_gnt, exp_gnt ? 12'h300 : p);
      end
      if (exp_gnt) begin
        ref_mem[12'h300] = 8'h77;
      end else begin
        ref_mem[p] = p[7:0];
        p = p + 1'b1;
      end
      next_cycle();
    end
    drive(1'b1, 1'b0, 1'b1, 12'h300, 8'h00, 1'b0, 1'b0, '0, '0);
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (cpu_d_out !== 8'h77) begin
      errors++;
      $display("FAIL starve_dma_write: got %h, expected 77", cpu_d_out);
    end
    next_cycle();
  endtask

  task automatic test_write_protect();
    logic [DW-1:0] exp_b00;
    drive(1'b1, 1'b1, 1'b0, 12'hB00, 8'hFF, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({ram_cs, ram_we} !== 2'b10) begin
      errors++;
      $display("FAIL wp_cpu_b00: got cs=%b we=%b, expected 1 0", ram_cs, ram_we);
    end
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 12'hAFF, 8'hFF, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++;
    if ({ram_cs, ram_we} !== 2'b11) begin
      errors++;
      $display("FAIL wp_cpu_aff: got cs=%b we=%b, expected 1 1", ram_cs, ram_we);
    end
    ref_mem[12'hAFF] = 8'hFF;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'hB00, 8'h11);
    @(negedge clk);
    checks++;
    if ({dma_gnt, ram_cs, ram_we, ram_re} !== 4'b1100) begin
      errors++;
      $display("FAIL wp_dma_b00: got gnt=%b cs=%b we=%b re=%b, expected 1 1 0 0",
               dma_gnt, ram_cs, ram_we, ram_re);
    end
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 12'hB00, 8'h00, 1'b0, 1'b0, '0, '0);
    exp_b00 = ref_mem[12'hB00];
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (cpu_d_out !== exp_b00) begin
      errors++;
      $display("FAIL wp_readback_b00: got %h, expected %h", cpu_d_out, exp_b00);
    end
    next_cycle();
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 2))
      0:       return AW'($urandom_range(0, 'hFF));
      1:       return AW'($urandom_range('hAF8, 'hB08));
      default: return AW'($urandom_range('h100, 'hFFF));
    endcase
  endfunction

  task automatic test_random();
    int            lost;
    logic          c_rq, d_win, c_win;
    logic          e_cs, e_we, e_re;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_dw;
    logic [DW-1:0] e_cpu_out, e_dma_out;
    logic          e_valid;
    lost = 0;
    e_cpu_out = '0; e_dma_out = '0; e_valid = 1'b0;
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), pick_addr(), DW'($urandom),
            $urandom_range(0, 9) < 6, 1'($urandom), pick_addr(), DW'($urandom));
      c_rq  = cpu_cs && (cpu_we || cpu_re);
      d_win = dma_req && (!c_rq || lost >= MW);
      c_win = c_rq && !d_win;
      e_cs = d_win || c_win;
      e_a  = d_win ? dma_a : (c_win ? cpu_a : '0);
      e_dw = d_win ? dma_d_in : (c_win ? cpu_d_in : '0);
      e_we = d_win ? (dma_we && int'(dma_a) < WL) : (c_win && cpu_we && int'(cpu_a) < WL);
      e_re = d_win ? !dma_we : (c_win && cpu_re);
      @(negedge clk);
      checks++;
      if ({dma_gnt, cpu_halt} !== {d_win, c_rq && d_win}) begin
        errors++;
        $display("FAIL rnd_grant_%0d: got gnt=%b halt=%b, expected %b %b",
                 n, dma_gnt, cpu_halt, d_win, c_rq && d_win);
      end
      checks++;
      if ({ram_cs, ram_we, ram_re, ram_a, ram_d_wr} !== {e_cs, e_we, e_re, e_a, e_dw}) begin
        errors++;
        $display("FAIL rnd_bus_%0d: got cs=%b we=%b re=%b a=%h d=%h, expected %b %b %b %h %h",
                 n, ram_cs, ram_we, ram_re, ram_a, ram_d_wr, e_cs, e_we, e_re, e_a, e_dw);
      end
      checks++;
      if ({cpu_d_out, dma_valid, dma_d_out} !== {e_cpu_out, e_valid, e_dma_out}) begin
        errors++;
        $display("FAIL rnd_return_%0d: got cpu_d=%h valid=%b dma_d=%h, expected %h %b %h",
                 n, cpu_d_out, dma_valid, dma_d_out, e_cpu_out, e_valid, e_dma_out);
      end
      e_cpu_out = (c_win && cpu_re) ? ref_mem[cpu_a] : '0;
      e_valid   = d_win && !dma_we;
      e_dma_out = (d_win && !dma_we) ? ref_mem[dma_a] : '0;
      if (e_cs && e_we) ref_mem[e_a] = e_dw;
      lost = (dma_req && !d_win) ? lost + 1 : 0;
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  task automatic test_reset_restart();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h050, 8'h00);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({ram_a, ram_we, cpu_halt, dma_valid} !== {AW'(i), 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL restart_a_%0d: got a=%h we=%b halt=%b valid=%b, expected %h 1 1 0",
                 i, ram_a, ram_we, cpu_halt, dma_valid, AW'(i));
      end
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int j = 0; j <= CD; j++) begin
      @(negedge clk);
      checks++;
      if ({cpu_halt, ram_a} !== {(j < CD), (j < CD) ? AW'(j) : 12'h000}) begin
        errors++;
        $display("FAIL reclear_%0d: got halt=%b a=%h, expected %b %h",
                 j, cpu_halt, ram_a, (j < CD), (j < CD) ? AW'(j) : 12'h000);
      end
      next_cycle();
    end
    for (int i = 0; i < CD; i++) ref_mem[i] = 8'h00;
    drive(1'b1, 1'b0, 1'b1, 12'h0A5, 8'h00, 1'b0, 1'b0, '0, '0);
    next_cycle();
    idle();
    @(negedge clk);
    checks++;
    if (cpu_d_out !== ref_mem[12'h0A5]) begin
      errors++;
      $display("FAIL reclear_readback: got %h, expected %h", cpu_d_out, ref_mem[12'h0A5]);
    end
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = seed_val(i);
    test_reset();
    test_cpu_rw();
    test_dma_read();
    test_starvation();
    test_write_protect();
    test_random();
    test_reset_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ram_access_arbiter
`default_nettype wire

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Sequencing and arbitration front-end for the AVR core's single-port data RAM. After reset it clears the low RAM region one word per cycle and holds the CPU in halt while it does so. It then shares the RAM port between the CPU and one DMA-style requester (display/bus-master side). The CPU has priority, and a bounded-wait rule stops the DMA requester from starving. It sits between the core/DMA master and the RAM macro, and owns the write-protection limit and the read-data return routing.

## Interface
Parameters:
- ADDR_BUS_WIDTH, 12, RAM address width.
- DATA_BUS_WIDTH, 8, RAM data width.
- CLEAR_DEPTH, 256, number of words zeroed after reset (addresses 0..CLEAR_DEPTH-1).
- WRITE_LIMIT, 12'hB00, writes to addresses >= WRITE_LIMIT are dropped.
- DMA_MAX_WAIT, 4, consecutive lost cycles after which DMA is forced through.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_cs / cpu_we / cpu_re  in  1 each  CPU select, write strobe, read strobe.
- cpu_a  in  ADDR_BUS_WIDTH  CPU address.
- cpu_d_in  in  DATA_BUS_WIDTH  CPU write data.
- cpu_d_out  out  DATA_BUS_WIDTH  CPU read data.
- cpu_halt  out  1  CPU stall.
- dma_req / dma_we  in  1 each  DMA request, DMA write (0 = read).
- dma_a  in  ADDR_BUS_WIDTH  DMA address.
- dma_d_in  in  DATA_BUS_WIDTH  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_valid  out  1  DMA read data valid.
- dma_d_out  out  DATA_BUS_WIDTH  DMA read data.
- ram_cs / ram_we / ram_re  out  1 each  RAM strobes.
- ram_a  out  ADDR_BUS_WIDTH  RAM address.
- ram_d_wr  out  DATA_BUS_WIDTH  RAM write data.
- ram_d_rd  in  DATA_BUS_WIDTH  RAM read data; 1-cycle registered latency.

## Operation
- States: CLEAR, RUN.
- rst=1: next state CLEAR; clr_cnt←0; wait_cnt←0; rd_owner←NONE.
- CLEAR:
  - ram_cs=ram_we=1, ram_a=clr_cnt, ram_d_wr=0; clr_cnt increments each cycle.
  - cpu_halt=1 and dma_gnt=0; requests are ignored and not queued.
  - Moves to RUN after the cycle that writes CLEAR_DEPTH-1.
- RUN, per cycle:
  - cpu_rq = cpu_cs & (cpu_we | cpu_re).
  - Grant DMA if dma_req & (!cpu_rq | wait_cnt==DMA_MAX_WAIT); otherwise grant CPU if cpu_rq.
- cpu_halt in RUN: 1 only in a cycle where cpu_rq=1 and DMA was forced. The CPU holds its request and is served the next cycle.
- wait_cnt:
  - +1 when dma_req=1 and the CPU is granted.
  - Cleared on a DMA grant or when dma_req=0.
  - Saturates at DMA_MAX_WAIT.
- Granted access: ram_* driven from the winner's a/d/strobes; ram_re = read strobe.
- Write protection: ram_we is forced to 0 when address >= WRITE_LIMIT. The grant is still consumed. For the CPU, ram_re follows cpu_re.
- Idle cycle: ram_cs=ram_we=ram_re=0; ram_a and ram_d_wr = 0.
- Read return: rd_owner register records CPU-read, DMA-read or NONE for the granted access.
  - CPU-read: cpu_d_out = ram_d_rd the next cycle; cpu_d_out = 0 whenever rd_owner != CPU.
  - DMA-read: dma_valid=1 and dma_d_out = ram_d_rd the next cycle; otherwise dma_d_out = 0.

## Timing
- Reset values: cpu_halt=1, dma_gnt=0, dma_valid=0, cpu_d_out=0, dma_d_out=0.
- Reset-cycle RAM outputs: ram_cs=1, ram_we=1, ram_a=0, ram_d_wr=0, since CLEAR begins in the first post-reset cycle.
- Clear duration: exactly CLEAR_DEPTH cycles from the first cycle with rst=0. cpu_halt falls on cycle CLEAR_DEPTH.
- rst asserted mid-CLEAR or mid-RUN: restart CLEAR at address 0 on the next edge. Any pending read return is discarded (dma_valid=0).
- ram_*, dma_gnt and cpu_halt (in RUN) are combinational from state and requests. dma_valid, cpu_d_out and dma_d_out arrive 1 cycle after the grant.
- Simultaneous cpu_rq and dma_req with wait_cnt < DMA_MAX_WAIT: CPU wins.
- Worst-case DMA latency: DMA_MAX_WAIT+1 cycles. Worst-case CPU stall: 1 cycle per DMA_MAX_WAIT+1.

## Structure
- Shared package: state enum {CLEAR, RUN}, rd_owner enum {NONE, CPU, DMA}, and default WRITE_LIMIT/CLEAR_DEPTH constants (reused by mega_ram parameters).
- One natural sub-module: ram_clear_seq, holding the counter, done flag and zero-write strobes.
- Arbitration, starvation counter and return mux stay in the top.

## Test plan
- Reset, then 256 idle cycles: ram_we=1 with ram_a stepping 0x000..0x0FF; cpu_halt=1 throughout and 0 on cycle 256. Memory model reads 0 at 0x00–0xFF.
- CPU write 0x5A to 0x120, then CPU read 0x120: one cycle later cpu_d_out=0x5A. dma_valid stays 0.
- CPU idle, DMA read of 0x050 after writing 0xC3 there: dma_gnt=1 that cycle; next cycle dma_valid=1 and dma_d_out=0xC3.
- CPU requests every cycle while DMA holds dma_req: CPU wins 4 cycles. On the 5th cycle dma_gnt=1 and cpu_halt=1; the CPU access completes on the 6th.
- CPU write 0xFF to 0xB00 and to 0xAFF: ram_we=0 for 0xB00, ram_we=1 for 0xAFF. Readback 0xB00 is unchanged.
- rst pulsed at clear cycle 100: clear restarts at ram_a=0 and cpu_halt stays 1 for a further 256 cycles.
